rr_burst_scheduler: RTL

- Round-robin scheduler that shares one burst-capable resource (e.g. a memory port or bus) among N requesters.
- Arbitrates among the requesters, then holds the grant for the winner's full burst, counting accepted beats.
- Releases the resource on burst completion or on a watchdog timeout.
- Sits between requester-side request vectors and the resource's beat handshake. All outputs are registered.

---
 rtl/rr_burst_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rr_burst_scheduler.sv
// rr_burst_scheduler
//   Round-robin scheduler sharing one burst-capable resource among N
//   requesters. A winner keeps the grant for its whole burst (len+1 beats,
//   counted on beat_i) and is released on the last beat or when the watchdog
//   sees TIMEOUT consecutive beat-less cycles. All outputs are registered.
//
// Ports
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   req_i    in   [N]     request vector, bit k = requester k
//   len_i    in   [N*LW]  per-requester burst length (beats-1), slice k at k*LW
//   beat_i   in   resource accepted one beat from the current owner
//   gnt_o    out  [N]     one-hot grant or zero
//   busy_o   out  a burst owns the resource
//   owner_o  out  [IW]    current or last owner index
//   done_o   out  one-cycle pulse, burst completed
//   abort_o  out  one-cycle pulse, burst killed by the watchdog
module rr_burst_scheduler #(
  parameter int unsigned N       = 4,
  parameter int unsigned IW      = 2,
  parameter int unsigned LW      = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TW      = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic [N*LW-1:0] len_i,
  input  logic            beat_i,
  output logic [N-1:0]    gnt_o,
  output logic            busy_o,
  output logic [IW-1:0]   owner_o,
  output logic            done_o,
  output logic            abort_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  // Abort fires on the edge that would make the beat-less run TIMEOUT long.
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;     // index searched first
  logic [LW:0]     cnt_q, cnt_d;     // beats still owed by the owner
  logic [TW-1:0]   wd_q, wd_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;

  logic [LW-1:0]   len_arr [N];
  logic            found;
  logic [IW-1:0]   win_idx, win_ptr, scan_idx;
  logic [LW-1:0]   win_len;
  int unsigned     scan_pos, scan_nxt;
  logic            grant_now;

  for (genvar k = 0; k < N; k++) begin : g_len
    assign len_arr[k] = len_i[k*LW +: LW];
  end

  // Round-robin search: first set request at or after ptr_q, wrapping.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    win_ptr  = '0;
    win_len  = '0;
    scan_idx = '0;
    scan_pos = 0;
    scan_nxt = 0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_pos = 32'(ptr_q) + i;
      if (scan_pos >= N) scan_pos = scan_pos - N;
      scan_idx = IW'(scan_pos);
      if (!found && req_i[scan_idx]) begin
        found    = 1'b1;
        win_idx  = scan_idx;
        win_len  = len_arr[scan_idx];
        scan_nxt = scan_pos + 1;
        if (scan_nxt == N) scan_nxt = 0;
        win_ptr  = IW'(scan_nxt);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    grant_now = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) grant_now = 1'b1;
      end
      BUSY: begin
        if (beat_i) begin
          wd_d  = '0;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == (LW+1)'(1)) begin
            done_d = 1'b1;
            if (found) begin
              grant_now = 1'b1;
            end else begin
              state_d = IDLE;
              gnt_d   = '0;
            end
          end
        end else if (TIMEOUT != 0 && wd_q == WD_LAST) begin
          // No re-arbitration here, so an abort always leaves one IDLE cycle.
          abort_d = 1'b1;
          state_d = IDLE;
          gnt_d   = '0;
          wd_d    = '0;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_now) begin
      state_d          = BUSY;
      gnt_d            = '0;
      gnt_d[win_idx]   = 1'b1;
      owner_d          = win_idx;
      ptr_d            = win_ptr;
      cnt_d            = (LW+1)'(win_len) + (LW+1)'(1);
      wd_d             = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign busy_o  = (state_q == BUSY);
  assign owner_o = owner_q;
  assign done_o  = done_q;
  assign abort_o = abort_q;

endmodule
